// File: rtl/pdl_puf_pkg.sv
// Shared types, default parameters and voting helper for the PDL PUF array controller.
package pdl_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_FIRE    = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_RELEASE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam int unsigned DEF_NUM_PUF       = 16;
   localparam int unsigned DEF_PDL_LEN       = 64;
   localparam int unsigned DEF_NUM_EVAL      = 7;
   localparam int unsigned DEF_RESET_CYCLES  = 4;
   localparam int unsigned DEF_SETTLE_CYCLES = 8;

   // A channel votes 1 when its ones-count exceeds this value.
   function automatic int unsigned majority_threshold(input int unsigned num_eval);
      return num_eval / 2;
   endfunction

endpackage

// File: rtl/pdl_vote_counter.sv
// Per-channel ones-counter with majority and unanimity decode.
module pdl_vote_counter
   import pdl_puf_pkg::*;
#(
   parameter int unsigned NUM_EVAL = DEF_NUM_EVAL
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   input  logic en,
   output logic majority_c,
   output logic stable_c
);

   localparam int unsigned CNT_W = $clog2(NUM_EVAL + 1);

   logic [CNT_W-1:0] ones_q;

   // Increment is capped at NUM_EVAL so the count can never wrap.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ones_q <= '0;
      end else if (inc && (ones_q != CNT_W'(NUM_EVAL))) begin
         ones_q <= ones_q + CNT_W'(1);
      end
   end

   assign majority_c = (ones_q > CNT_W'(majority_threshold(NUM_EVAL)));
   assign stable_c   = en & ((ones_q == '0) | (ones_q == CNT_W'(NUM_EVAL)));

endmodule

// File: rtl/pdl_puf_array_ctrl.sv
// Sequencer for a PDL PUF array: arm, launch, sample and majority-vote each channel
// over NUM_EVAL repeated evaluations of a latched challenge.
module pdl_puf_array_ctrl
   import pdl_puf_pkg::*;
#(
   parameter int unsigned NUM_PUF       = DEF_NUM_PUF,
   parameter int unsigned PDL_LEN       = DEF_PDL_LEN,
   parameter int unsigned NUM_EVAL      = DEF_NUM_EVAL,
   parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [PDL_LEN-1:0] challenge_top,
   input  logic [PDL_LEN-1:0] challenge_bottom,
   input  logic [NUM_PUF-1:0] channel_en,
   output logic [PDL_LEN-1:0] s_tp,
   output logic [PDL_LEN-1:0] s_btm,
   output logic [NUM_PUF-1:0] s1,
   output logic [NUM_PUF-1:0] s2,
   output logic               puf_reset,
   input  logic [NUM_PUF-1:0] puf_resp,
   output logic               busy,
   output logic               done,
   output logic [NUM_PUF-1:0] response,
   output logic [NUM_PUF-1:0] stable
);

   localparam int unsigned CNT_W     = $clog2(NUM_EVAL + 1);
   localparam int unsigned PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   eval_q, eval_d;
   logic               accept_c;
   logic               sample_c;
   logic               fire_c;
   logic [NUM_PUF-1:0] en_q;
   logic [NUM_PUF-1:0] resp_meta_q, resp_sync_q;
   logic [NUM_PUF-1:0] maj_c, stab_c;

   (* KEEP = "TRUE" *) logic [NUM_PUF-1:0] s1_q;
   (* KEEP = "TRUE" *) logic [NUM_PUF-1:0] s2_q;

   assign s1 = s1_q;
   assign s2 = s2_q;

   // State, phase timer and evaluation counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         eval_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         eval_q  <= eval_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      eval_d   = eval_q;
      accept_c = 1'b0;
      sample_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               eval_d   = '0;
               tmr_d    = '0;
               state_d  = ST_ARM;
            end
         end
         ST_ARM: begin
            if (tmr_q == TMR_W'(RESET_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = ST_FIRE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_FIRE: begin
            if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_SAMPLE: begin
            sample_c = 1'b1;
            state_d  = ST_RELEASE;
         end
         ST_RELEASE: begin
            eval_d  = eval_q + CNT_W'(1);
            state_d = (eval_q == CNT_W'(NUM_EVAL - 1)) ? ST_DONE : ST_ARM;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   assign fire_c = (state_d == ST_FIRE) || (state_d == ST_SAMPLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         s_tp      <= '0;
         s_btm     <= '0;
         en_q      <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         puf_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         response  <= '0;
         stable    <= '0;
      end else begin
         if (accept_c) begin
            s_tp  <= challenge_top;
            s_btm <= challenge_bottom;
            en_q  <= channel_en;
         end
         s1_q      <= fire_c ? en_q : '0;
         s2_q      <= fire_c ? en_q : '0;
         puf_reset <= ~fire_c;
         busy      <= (state_d != ST_IDLE);
         done      <= (state_d == ST_DONE);
         if (state_d == ST_DONE) begin
            response <= maj_c;
            stable   <= stab_c;
         end
      end
   end

   // Arbiter outputs are asynchronous to the race; two flops before use.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_meta_q <= '0;
         resp_sync_q <= '0;
      end else begin
         resp_meta_q <= puf_resp;
         resp_sync_q <= resp_meta_q;
      end
   end

   for (genvar i = 0; i < NUM_PUF; i++) begin : g_vote
      pdl_vote_counter #(
         .NUM_EVAL (NUM_EVAL)
      ) u_vote (
         .clk        (clk),
         .reset      (reset),
         .clr        (accept_c),
         .inc        (sample_c & en_q[i] & resp_sync_q[i]),
         .en         (en_q[i]),
         .majority_c (maj_c[i]),
         .stable_c   (stab_c[i])
      );
   end

endmodule

// File: tb/tb_pdl_puf_array_ctrl.sv
// Directed scoreboard bench for pdl_puf_array_ctrl with a per-evaluation PUF response model.
module tb_pdl_puf_array_ctrl;

   localparam int NP  = 16;
   localparam int PL  = 64;
   localparam int NE  = 7;
   localparam int RC  = 4;
   localparam int SC  = 8;
   localparam int LAT = NE * (RC + SC + 2) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [PL-1:0] challenge_top;
   logic [PL-1:0] challenge_bottom;
   logic [NP-1:0] channel_en;
   logic [PL-1:0] s_tp, s_btm;
   logic [NP-1:0] s1, s2;
   logic          puf_reset;
   logic [NP-1:0] puf_resp;
   logic          busy, done;
   logic [NP-1:0] response, stable;

   pdl_puf_array_ctrl #(
      .NUM_PUF       (NP),
      .PDL_LEN       (PL),
      .NUM_EVAL      (NE),
      .RESET_CYCLES  (RC),
      .SETTLE_CYCLES (SC)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .challenge_top    (challenge_top),
      .challenge_bottom (challenge_bottom),
      .channel_en       (channel_en),
      .s_tp             (s_tp),
      .s_btm            (s_btm),
      .s1               (s1),
      .s2               (s2),
      .puf_reset        (puf_reset),
      .puf_resp         (puf_resp),
      .busy             (busy),
      .done             (done),
      .response         (response),
      .stable           (stable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PUF model: pattern row selected by the evaluation index of the current run.
   logic [NP-1:0] resp_pat [0:7];
   logic [3:0]    eval_idx = 4'd0;
   logic          prev_prst = 1'b1;
   logic [2:0]    pat_sel;

   always @(posedge clk) begin
      prev_prst <= puf_reset;
      if (busy !== 1'b1)               eval_idx <= 4'd0;
      else if (!prev_prst && puf_reset) eval_idx <= eval_idx + 4'd1;
   end
   assign pat_sel  = (eval_idx >= 4'(NE)) ? 3'(NE - 1) : eval_idx[2:0];
   assign puf_resp = resp_pat[pat_sel];

   typedef struct {
      logic [NP-1:0] resp;
      logic [NP-1:0] stab;
      logic [PL-1:0] tp;
      logic [PL-1:0] btm;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_pat_all(input logic [NP-1:0] v);
      for (int e = 0; e < 8; e++) resp_pat[e] = v;
   endtask

   // Drive a start pulse; optionally push the model's expected result.
   task automatic launch(input logic [PL-1:0] tp, input logic [PL-1:0] btm,
                         input logic [NP-1:0] en, input bit push, output int k);
      exp_t ex;
      int   ones;
      if (push) begin
         for (int ch = 0; ch < NP; ch++) begin
            ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(resp_pat[e][ch] & en[ch]);
            ex.resp[ch] = (ones > NE / 2);
            ex.stab[ch] = en[ch] && (ones == 0 || ones == NE);
         end
         ex.tp  = tp;
         ex.btm = btm;
         ex.cyc = cyc + LAT;
         sb.push_back(ex);
      end
      challenge_top    = tp;
      challenge_bottom = btm;
      channel_en       = en;
      start            = 1'b1;
      k                = cyc;
      tick();
      start = 1'b0;
   endtask

   // Watch a run; quick=1 returns in the cycle after done, ready for a back-to-back start.
   task automatic run_to_done(input int k, input logic [NP-1:0] en, input int start_a,
                              input int start_b, input int chg_at, input bit quick);
      logic [NP-1:0] s_or;
      exp_t          ex;
      int            rel;
      int            n_done;
      s_or   = '0;
      n_done = 0;
      for (int i = 0; i < LAT + 20; i++) begin
         rel   = cyc - k;
         start = (rel == start_a) || (rel == start_b);
         if (rel == chg_at) begin
            challenge_top    = ~challenge_top;
            challenge_bottom = ~challenge_bottom;
            channel_en       = ~channel_en;
         end
         if (rel == 1) begin
            check("arm_busy", busy, 1);
            check("arm_puf_reset", puf_reset, 1);
            check("arm_s1", s1, 0);
         end
         if (rel == RC + 1) begin
            check("fire_s1", s1, en);
            check("fire_s2", s2, en);
            check("fire_puf_reset", puf_reset, 0);
         end
         s_or |= s1 | s2;
         if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
               check("done_unexpected", done, 0);
            end else begin
               ex = sb.pop_front();
               check("done_cycle", cyc, ex.cyc);
               check("response", response, ex.resp);
               check("stable", stable, ex.stab);
               check("s_tp", s_tp, ex.tp);
               check("s_btm", s_btm, ex.btm);
               check("disabled_s1_s2", s_or & ~en, 0);
            end
         end
         if (n_done > 0 && rel == LAT + 1) begin
            check("busy_after_done", busy, 0);
            if (quick) break;
         end
         tick();
      end
      start = 1'b0;
      check("done_count", n_done, 1);
   endtask

   initial begin
      int k;
      int n_done;
      logic [NP-1:0] p;
      reset            = 1'b1;
      start            = 1'b0;
      challenge_top    = '0;
      challenge_bottom = '0;
      channel_en       = '0;
      set_pat_all('0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (10) tick();

      check("rst_puf_reset", puf_reset, 1);
      check("rst_s1", s1, 0);
      check("rst_s2", s2, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_response", response, 0);
      check("rst_stable", stable, 0);
      check("rst_s_tp", s_tp, 0);

      // Constant response on all channels.
      set_pat_all(16'h00F3);
      launch(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 16'hFFFF, 1'b1, k);
      run_to_done(k, 16'hFFFF, -1, -1, -1, 1'b1);

      // Channel 2 votes 4 of 7, started in the cycle busy falls.
      p = 16'h00F3;
      resp_pat[0] = p | 16'h0004;
      resp_pat[1] = p;
      resp_pat[2] = p | 16'h0004;
      resp_pat[3] = p | 16'h0004;
      resp_pat[4] = p;
      resp_pat[5] = p | 16'h0004;
      resp_pat[6] = p;
      resp_pat[7] = p;
      launch(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 16'hFFFF, 1'b1, k);
      run_to_done(k, 16'hFFFF, -1, -1, -1, 1'b1);

      // Channel 2 votes 3 of 7.
      resp_pat[3] = p;
      launch(64'hDEAD_BEEF_0000_FFFF, 64'h1111_2222_3333_4444, 16'hFFFF, 1'b1, k);
      run_to_done(k, 16'hFFFF, -1, -1, -1, 1'b1);

      // Only channel 0 enabled while every arbiter reports 1.
      set_pat_all(16'hFFFF);
      launch(64'hCAFE_F00D_1234_5678, 64'h8765_4321_0F0F_F0F0, 16'h0001, 1'b1, k);
      run_to_done(k, 16'h0001, -1, -1, -1, 1'b1);

      // Starts and input changes during a run have no effect.
      set_pat_all(16'h00F3);
      launch(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 16'hFFFF, 1'b1, k);
      run_to_done(k, 16'hFFFF, 20, 50, 30, 1'b0);

      // Reset mid-run: immediate idle, cleared results, no done.
      set_pat_all(16'h0F0F);
      launch(64'h1357_9BDF_2468_ACE0, 64'h0, 16'hFFFF, 1'b0, k);
      while (cyc - k < 40) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_puf_reset", puf_reset, 1);
      check("midrst_s1", s1, 0);
      check("midrst_s2", s2, 0);
      check("midrst_done", done, 0);
      check("midrst_response", response, 0);
      check("midrst_stable", stable, 0);
      n_done = 0;
      for (int i = 0; i < LAT + 5; i++) begin
         if (done === 1'b1) n_done++;
         tick();
      end
      check("midrst_no_done", n_done, 0);

      // Fresh start after reset completes normally.
      launch(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 16'hFFFF, 1'b1, k);
      run_to_done(k, 16'hFFFF, -1, -1, -1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pdl_puf_array_ctrl.md
# pdl_puf_array_ctrl

Sequencing controller for an array of `pdl_puf` instances. It replaces static switch/LED stimulus with full per-stage challenge vectors, a per-channel enable mask, and a repeated-evaluation engine. The engine arms the arbiters, launches the race, samples the responses, and majority-votes each channel over several evaluations. It sits between the host/challenge source and the PUF array; the PUF instances themselves stay outside the block.

## Interface

Parameters:
- `NUM_PUF`, 16: number of PUF channels driven.
- `PDL_LEN`, 64: switch stages per PDL line (challenge width).
- `NUM_EVAL`, 7: evaluations per challenge; must be odd, ≥1.
- `RESET_CYCLES`, 4: arbiter reset hold per evaluation; ≥1.
- `SETTLE_CYCLES`, 8: race settle time before sampling; ≥1.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high block reset.
- `start`  in  1  request an evaluation run; honoured only in IDLE.
- `challenge_top`  in  PDL_LEN  top-line challenge; latched on accepted start.
- `challenge_bottom`  in  PDL_LEN  bottom-line challenge; latched on accepted start.
- `channel_en`  in  NUM_PUF  channel enable mask; latched on accepted start.
- `s_tp`  out  PDL_LEN  latched top challenge to every PUF.
- `s_btm`  out  PDL_LEN  latched bottom challenge to every PUF.
- `s1`, `s2`  out  NUM_PUF  race launch signals, one pair per channel.
- `puf_reset`  out  1  arbiter reset to all PUFs.
- `puf_resp`  in  NUM_PUF  raw arbiter outputs.
- `busy`  out  1  high from ARM through DONE.
- `done`  out  1  one-cycle pulse when results update.
- `response`  out  NUM_PUF  majority-voted response per channel.
- `stable`  out  NUM_PUF  1 = all NUM_EVAL samples agreed.

## Operation

- States: IDLE → ARM → FIRE → SAMPLE → RELEASE, then either back to ARM or on to DONE → IDLE.
- IDLE
  - `start`=1 latches the challenges and `channel_en`.
  - Clears the eval counter and all per-channel ones-counters.
  - Moves to ARM.
- ARM: `puf_reset`=1 and `s1`/`s2`=0 for RESET_CYCLES cycles.
- FIRE: `puf_reset`=0; `s1[i]`=`s2[i]`=`channel_en_q[i]` for SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): keep FIRE outputs; `ones[i]` += `puf_resp[i] & channel_en_q[i]`.
- RELEASE (1 cycle)
  - `s1`/`s2`=0, `puf_reset`=1, eval counter += 1.
  - If the counter equals NUM_EVAL, go to DONE; otherwise go to ARM.
- DONE (1 cycle)
  - `response[i]` = (`ones[i]` > NUM_EVAL/2).
  - `stable[i]` = `channel_en_q[i]` & (`ones[i]`==0 | `ones[i]`==NUM_EVAL).
  - `done`=1, then go to IDLE.
- Disabled channels: `s1`/`s2` held at 0; `response`=0; `stable`=0.
- Counter widths are $clog2(NUM_EVAL+1). Counters never wrap, because they saturate structurally at NUM_EVAL.
- `start` while busy is ignored and not queued. The latched challenge is immune to input changes during a run.
- In IDLE, `puf_reset`=1.

## Timing

- Reset values:
  - state IDLE; `s1`/`s2`=0; `puf_reset`=1; `busy`=0; `done`=0.
  - `response`=0; `stable`=0; `s_tp`/`s_btm`=0.
- All outputs are registered.
- `start` sampled high in IDLE at cycle k → ARM occupies cycles k+1..k+RESET_CYCLES.
- One evaluation takes RESET_CYCLES+SETTLE_CYCLES+2 cycles.
- `done` is high at cycle k + NUM_EVAL·(RESET_CYCLES+SETTLE_CYCLES+2) + 1; with defaults, k+99.
- `response`/`stable` change only in the DONE cycle and hold until the next DONE.
- `busy` falls in the cycle after DONE; a new `start` is accepted that same cycle.
- `reset` mid-run, on the next edge:
  - forces IDLE; drops `s1`/`s2`; raises `puf_reset`.
  - clears `response`/`stable`.
  - no `done` pulse is emitted.
- `puf_resp` is asynchronous to the race. It is double-flopped; SAMPLE uses the synchronised value, and SETTLE_CYCLES ≥ 3 covers the 2-cycle sync delay.

## Structure

- Package `pdl_puf_pkg` holds:
  - the state enum (IDLE, ARM, FIRE, SAMPLE, RELEASE, DONE);
  - default parameter constants;
  - the majority-threshold function.
- Sub-module `pdl_vote_counter`, one per channel:
  - ones-counter with synchronous clear/increment;
  - produces the majority and stable outputs.
- Top module: FSM, phase timer, eval counter, challenge/mask latches, `puf_resp` synchroniser.
- `(* KEEP = "TRUE" *)` on the `s1`/`s2` nets.

## Test plan

- Reset, then idle 10 cycles → `puf_reset`=1, `s1`/`s2`=0, `busy`=0, `done`=0, `response`=0.
- `start` with `challenge_top`=64'hA5A5…, `channel_en`=16'hFFFF, and the PUF model returning constant 16'h00F3 → `done` at k+99, `response`=16'h00F3, `stable`=16'hFFFF, `s_tp`=64'hA5A5….
- Channel 2 response toggles 1,0,1,1,0,1,0 (4 ones of 7) → `response[2]`=1, `stable[2]`=0; with 3 ones → `response[2]`=0.
- `channel_en`=16'h0001 → `s1[15:1]`/`s2[15:1]` never rise; `response[15:1]`=0, `stable[15:1]`=0.
- `start` pulsed at k+20 and k+50 during a run → exactly one `done`, at k+99; challenge changed at k+30 leaves `s_tp` unchanged.
- `reset` at k+40 → next cycle IDLE, `busy`=0, no `done`; a fresh `start` completes normally 99 cycles later.
